// File: rtl/lockin_pkg.sv
// Shared types and constants for the lock-in I/Q demodulator.
package lockin_pkg;
  localparam int SAMPLE_W = 16;
  localparam int PROD_W   = 32;

  typedef logic [1:0] state_t;

  // FSM encoding: one pass through MUL_I -> MUL_Q -> ACC per accepted sample.
  localparam state_t IDLE  = 2'd0;
  localparam state_t MUL_I = 2'd1;
  localparam state_t MUL_Q = 2'd2;
  localparam state_t ACC   = 2'd3;
endpackage

// File: rtl/lockin_mul16s.sv
// Registered 16x16 signed multiplier, one cycle latency (single MAC tile).
module lockin_mul16s
  import lockin_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic signed [SAMPLE_W-1:0] a,
  input  logic signed [SAMPLE_W-1:0] b,
  output logic signed [PROD_W-1:0]   p
);
  logic signed [PROD_W-1:0] a_x, b_x;

  // Sign-extend so the full 32-bit product is formed; -32768^2 still fits.
  assign a_x = {{(PROD_W-SAMPLE_W){a[SAMPLE_W-1]}}, a};
  assign b_x = {{(PROD_W-SAMPLE_W){b[SAMPLE_W-1]}}, b};

  // Product register, only loaded while the FSM is in a multiply state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     p <= '0;
    else if (en) p <= a_x * b_x;
  end
endmodule

// File: rtl/lockin_demod.sv
// Lock-in I/Q demodulator with boxcar decimation over 2^LOG2_DEC samples.
// One shared multiplier: I product, then Q product, then accumulate.
module lockin_demod
  import lockin_pkg::*;
#(
  parameter int LOG2_DEC = 10,
  parameter int ACC_W    = 32 + LOG2_DEC
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic signed [SAMPLE_W-1:0] sin,
  input  logic signed [SAMPLE_W-1:0] cos,
  output logic signed [31:0]         x_out,
  output logic signed [31:0]         y_out,
  output logic                       out_valid
);
  state_t                     state;
  logic signed [SAMPLE_W-1:0] s_r, c_r, sn_r, mul_b;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    acc_i, acc_q, prod_x, sum_i, sum_q;
  logic [LOG2_DEC-1:0]        cnt;
  logic                       accept, mul_en, block_end;

  // Ready is gated by rst so it reads 0 while reset is held.
  assign sample_ready = !rst && !clear && (state == IDLE);
  assign accept       = sample_valid && sample_ready;

  assign mul_en = (state == MUL_I) || (state == MUL_Q);
  assign mul_b  = (state == MUL_Q) ? sn_r : c_r;

  lockin_mul16s u_mul (
    .clk (clk),
    .rst (rst),
    .en  (mul_en),
    .a   (s_r),
    .b   (mul_b),
    .p   (prod)
  );

  assign prod_x    = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign sum_i     = acc_i + prod_x;
  assign sum_q     = acc_q + prod_x;
  assign block_end = (state == ACC) && (cnt == '1);

  // Capture sample and references on accept; the DDS moves on afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_r  <= '0;
      c_r  <= '0;
      sn_r <= '0;
    end else if (accept) begin
      s_r  <= sample;
      c_r  <= cos;
      sn_r <= sin;
    end
  end

  // Sequencer, accumulators and block output. Taking bits [LOG2_DEC +: 32]
  // of an ACC_W = 32+LOG2_DEC accumulator is the arithmetic right shift
  // (floor division) by 2^LOG2_DEC, with no rounding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc_i     <= '0;
      acc_q     <= '0;
      cnt       <= '0;
      x_out     <= '0;
      y_out     <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      acc_i     <= '0;
      acc_q     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE:  if (accept) state <= MUL_I;
        MUL_I: state <= MUL_Q;
        MUL_Q: begin
          acc_i <= sum_i;
          state <= ACC;
        end
        ACC: begin
          state <= IDLE;
          if (block_end) begin
            x_out     <= acc_i[LOG2_DEC +: 32];
            y_out     <= sum_q[LOG2_DEC +: 32];
            acc_i     <= '0;
            acc_q     <= '0;
            cnt       <= '0;
            out_valid <= 1'b1;
          end else begin
            acc_q <= sum_q;
            cnt   <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lockin_demod.sv
// Scoreboard bench for lockin_demod with LOG2_DEC=2 (4-sample blocks).
module tb_lockin_demod;
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               clear = 1'b0;
  logic               sample_valid = 1'b0;
  logic               sample_ready;
  logic signed [15:0] sample = '0, sin = '0, cos = '0;
  logic signed [31:0] x_out, y_out;
  logic               out_valid;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  longint mx = 0, my = 0;
  int     mcnt = 0;

  lockin_demod #(.LOG2_DEC(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample       (sample),
    .sin          (sin),
    .cos          (cos),
    .x_out        (x_out),
    .y_out        (y_out),
    .out_valid    (out_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 0; mcnt = 0;
  endtask

  // Reference: exact 64-bit sums, floor-divided by 4 at block end.
  task automatic model_accept(input logic signed [15:0] s, c, sn);
    exp_t e;
    mx += longint'(s) * longint'(c);
    my += longint'(s) * longint'(sn);
    mcnt++;
    if (mcnt == 4) begin
      e.x   = 32'(mx >>> 2);
      e.y   = 32'(my >>> 2);
      e.cyc = cyc;
      exp_q.push_back(e);
      model_reset();
    end
  endtask

  task automatic send(input logic signed [15:0] s, c, sn);
    int n = 0;
    @(negedge clk);
    sample = s; cos = c; sin = sn; sample_valid = 1'b1;
    while (!sample_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!sample_ready) chk("accept_timeout", 32'd0, 32'd1);
    else begin
      @(posedge clk); #1;
      model_accept(s, c, sn);
    end
    sample_valid = 1'b0;
  endtask

  // Output side of the scoreboard, including 3-cycle latency check.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("x_out", x_out, e.x);
        chk("y_out", y_out, e.y);
        chk("latency", 32'(cyc - e.cyc), 32'd3);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nacc;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(sample_ready), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_x", x_out, 32'd0);
    chk("rst_y", y_out, 32'd0);
    rst = 1'b0;
    #1 chk("ready_after_rst", 32'(sample_ready), 32'd1);

    // DC in-phase
    repeat (4) send(16384, 16384, 0);
    repeat (6) @(negedge clk);
    chk("dc_x", x_out, 32'd268435456);
    chk("dc_y", y_out, 32'd0);

    // Extreme operands
    repeat (4) send(-16'sd32768, -16'sd32768, 16'sd32767);
    repeat (6) @(negedge clk);
    chk("ext_x", x_out, 32'd1073741824);
    chk("ext_y", y_out, -32'sd1073709056);

    // Backpressure: valid held for 40 cycles
    @(negedge clk);
    sample_valid = 1'b1; cos = 300; sin = -200; nacc = 0;
    for (int i = 0; i < 40; i++) begin
      sample = 16'(i * 100);
      chk("bp_ready", 32'(sample_ready), 32'(i % 4 == 0));
      if (sample_ready) begin
        @(posedge clk); #1;
        model_accept(sample, cos, sin);
        nacc++;
      end
      @(negedge clk);
    end
    sample_valid = 1'b0;
    chk("bp_accepts", 32'(nacc), 32'd10);
    // Drop the 2-sample partial block
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_reset();

    // Quadrature cancellation, then a fresh block with negative floor
    send(1000, 500, 1000);
    send(1000, 500, -1000);
    send(1000, 500, 1000);
    send(1000, 500, -1000);
    repeat (6) @(negedge clk);
    chk("quad_x", x_out, 32'd500000);
    chk("quad_y", y_out, 32'd0);
    send(1, 1, 2); send(1, 1, 2); send(1, 1, 2); send(-6, 1, 2);
    repeat (6) @(negedge clk);
    chk("floor_x", x_out, -32'sd1);
    chk("floor_y", y_out, -32'sd2);

    // Clear mid-block, same cycle as valid
    send(100, 100, 100);
    send(100, 100, 100);
    @(negedge clk);
    sample = 77; sample_valid = 1'b1; clear = 1'b1;
    #1 chk("clear_ready", 32'(sample_ready), 32'd0);
    @(posedge clk); #1;
    clear = 1'b0; sample_valid = 1'b0;
    model_reset();
    repeat (8) @(negedge clk);
    chk("clear_hold_x", x_out, -32'sd1);
    chk("clear_hold_y", y_out, -32'sd2);
    repeat (4) send(200, 10, -10);
    repeat (6) @(negedge clk);
    chk("after_clear_x", x_out, 32'd2000);
    chk("after_clear_y", y_out, -32'sd2000);

    // Reset pulsed while in MUL_Q
    send(50, 50, 50);
    send(50, 50, 50);
    send(50, 50, 50);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_x", x_out, 32'd0);
    chk("midrst_y", y_out, 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_ready", 32'(sample_ready), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1 chk("midrst_ready_rel", 32'(sample_ready), 32'd1);
    repeat (4) send(3, 4, 5);
    repeat (6) @(negedge clk);
    chk("post_rst_x", x_out, 32'd12);
    chk("post_rst_y", y_out, 32'd15);

    chk("pending", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
